// File: rtl/branch_resolver.sv
// Execute-stage branch resolver: decodes comparator flags against a condition code,
// computes the branch target, and holds a redirect toward fetch until acknowledged.
module branch_resolver #(
  parameter int WIDTH = 16
) (
  input  logic             CLK,
  input  logic             Reset_n,
  input  logic             issue_valid,
  output logic             issue_ready,
  input  logic [2:0]       cond,
  input  logic [WIDTH-1:0] pc,
  input  logic [WIDTH-1:0] offset,
  input  logic             LT,
  input  logic             Equal,
  input  logic             flush,
  output logic             resolve_valid,
  output logic             taken,
  output logic             redirect,
  output logic [WIDTH-1:0] redirect_pc,
  input  logic             redirect_ack,
  output logic [WIDTH-1:0] taken_count
);

  typedef enum logic [1:0] {
    S_IDLE     = 2'd0,
    S_EVAL     = 2'd1,
    S_REDIRECT = 2'd2
  } state_e;

  state_e           state_q, state_d;
  logic [2:0]       cond_q;
  logic             lt_q, eq_q;
  logic [WIDTH-1:0] target_q;
  logic [WIDTH-1:0] count_q;
  logic             ready_q, redirect_q;
  logic             cond_taken;
  logic             accept;
  logic             count_inc;

  always_comb begin
    cond_taken = 1'b0;
    unique case (cond_q)
      3'b000:  cond_taken = eq_q;
      3'b001:  cond_taken = ~eq_q;
      3'b010:  cond_taken = lt_q;
      3'b011:  cond_taken = ~lt_q;
      3'b100:  cond_taken = ~lt_q & ~eq_q;
      3'b101:  cond_taken = lt_q | eq_q;
      3'b110:  cond_taken = 1'b1;
      default: cond_taken = 1'b0;
    endcase
  end

  // NOTE: every signal assigned in always_comb gets a default first, so no path
  // leaves it unassigned and no latch is inferred.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE:     if (issue_valid) state_d = S_EVAL;
      S_EVAL:     state_d = cond_taken ? S_REDIRECT : S_IDLE;
      S_REDIRECT: if (redirect_ack) state_d = S_IDLE;
      default:    state_d = S_IDLE;
    endcase
    // Flush overrides every transition, including an accept from IDLE.
    if (flush) state_d = S_IDLE;
  end

  assign accept    = (state_q == S_IDLE) & issue_valid & ~flush;
  assign count_inc = (state_q == S_EVAL) & ~flush & cond_taken & (count_q != '1);

  // NOTE: sequential state uses non-blocking assignments only, so every register
  // samples the pre-edge values regardless of statement order.
  always_ff @(posedge CLK or negedge Reset_n) begin
    if (!Reset_n) begin
      state_q    <= S_IDLE;
      ready_q    <= 1'b1;
      redirect_q <= 1'b0;
      cond_q     <= 3'b000;
      lt_q       <= 1'b0;
      eq_q       <= 1'b0;
      target_q   <= '0;
      count_q    <= '0;
    end else begin
      state_q    <= state_d;
      ready_q    <= (state_d == S_IDLE);
      redirect_q <= (state_d == S_REDIRECT);
      if (accept) begin
        cond_q   <= cond;
        lt_q     <= LT;
        eq_q     <= Equal;
        target_q <= pc + offset + WIDTH'(1);
      end
      if (count_inc) count_q <= count_q + WIDTH'(1);
    end
  end

  // The resolve pulse is masked combinationally so a flush hides it in its own cycle.
  assign resolve_valid = (state_q == S_EVAL) & ~flush;
  assign taken         = resolve_valid & cond_taken;
  assign issue_ready   = ready_q;
  assign redirect      = redirect_q;
  assign redirect_pc   = target_q;
  assign taken_count   = count_q;

endmodule

// File: tb/tb_branch_resolver.sv
// Self-checking bench for branch_resolver: directed vector table, corner-case
// sequences, and randomized branches checked against a relation-level model.
module tb_branch_resolver;

  logic        CLK = 1'b0;
  logic        Reset_n;
  logic        issue_valid, flush, redirect_ack;
  logic [2:0]  cond;
  logic [15:0] pc, offset;
  logic        lt_s, eq_s;
  logic        issue_ready, resolve_valid, taken, redirect;
  logic [15:0] redirect_pc, taken_count;

  // Narrow instance used to reach counter saturation in few cycles.
  logic        s_rst_n, s_issue, s_ack, s_ready, s_rv, s_taken, s_redirect;
  logic [3:0]  s_rpc, s_count;

  int tests = 0;
  int fails = 0;
  logic [15:0] exp_count = 16'd0;

  always #5 CLK = ~CLK;

  branch_resolver #(.WIDTH(16)) dut (
    .CLK(CLK), .Reset_n(Reset_n), .issue_valid(issue_valid), .issue_ready(issue_ready),
    .cond(cond), .pc(pc), .offset(offset), .LT(lt_s), .Equal(eq_s), .flush(flush),
    .resolve_valid(resolve_valid), .taken(taken), .redirect(redirect),
    .redirect_pc(redirect_pc), .redirect_ack(redirect_ack), .taken_count(taken_count)
  );

  branch_resolver #(.WIDTH(4)) dut_small (
    .CLK(CLK), .Reset_n(s_rst_n), .issue_valid(s_issue), .issue_ready(s_ready),
    .cond(3'b110), .pc(4'h3), .offset(4'h1), .LT(1'b0), .Equal(1'b0), .flush(1'b0),
    .resolve_valid(s_rv), .taken(s_taken), .redirect(s_redirect),
    .redirect_pc(s_rpc), .redirect_ack(s_ack), .taken_count(s_count)
  );

  typedef struct {
    logic [2:0]  c;
    logic        l;
    logic        e;
    logic [15:0] p;
    logic [15:0] o;
    logic        tk;
    logic [15:0] tgt;
  } vec_t;

  vec_t vecs[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic add(input logic [2:0] c, input logic l, input logic e, input logic [15:0] p,
                     input logic [15:0] o, input logic tk, input logic [15:0] tgt);
    vec_t v;
    v = '{c, l, e, p, o, tk, tgt};
    vecs.push_back(v);
  endtask

  task automatic edge_();
    @(posedge CLK);
    #1;
  endtask

  // Full branch lifetime from an IDLE cycle. flush_at: 0 none, 1 during EVAL,
  // 2 in REDIRECT at the release edge.
  task automatic run_branch(input logic [2:0] c, input logic l, input logic e,
                            input logic [15:0] p, input logic [15:0] o,
                            input logic exp_tk, input logic [15:0] exp_tgt,
                            input int ack_delay, input int flush_at);
    check("ready_before_issue", issue_ready, 1);
    issue_valid = 1; cond = c; pc = p; offset = o; lt_s = l; eq_s = e;
    flush = 0; redirect_ack = 0;
    edge_();
    // Scramble inputs during EVAL: only the accept-edge values may matter.
    issue_valid = 0; lt_s = ~l; eq_s = ~e; cond = 3'($urandom); pc = 16'($urandom);
    offset = 16'($urandom); redirect_ack = 1'($urandom); flush = (flush_at == 1);
    #1;
    if (flush_at == 1) begin
      check("flush_eval_rv", resolve_valid, 0);
      check("flush_eval_taken", taken, 0);
      edge_();
      flush = 0; redirect_ack = 0; #1;
      check("flush_eval_redirect", redirect, 0);
      check("flush_eval_ready", issue_ready, 1);
      check("flush_eval_count", taken_count, exp_count);
      return;
    end
    check("eval_rv", resolve_valid, 1);
    check("eval_taken", taken, exp_tk);
    check("eval_redirect", redirect, 0);
    check("eval_ready", issue_ready, 0);
    if (exp_tk && exp_count != 16'hFFFF) exp_count++;
    edge_();
    redirect_ack = 0; #1;
    check("post_eval_rv", resolve_valid, 0);
    check("post_eval_taken", taken, 0);
    check("post_eval_count", taken_count, exp_count);
    if (!exp_tk) begin
      check("nt_redirect", redirect, 0);
      check("nt_ready", issue_ready, 1);
      return;
    end
    check("redir_high", redirect, 1);
    check("redir_pc", redirect_pc, exp_tgt);
    check("redir_ready", issue_ready, 0);
    for (int k = 0; k < ack_delay; k++) begin
      issue_valid = 1'($urandom);
      edge_();
      check("hold_redirect", redirect, 1);
      check("hold_pc", redirect_pc, exp_tgt);
      check("hold_ready", issue_ready, 0);
      check("hold_rv", resolve_valid, 0);
    end
    issue_valid = 0;
    if (flush_at == 2) begin
      flush = 1; redirect_ack = 1'($urandom);
    end else begin
      redirect_ack = 1;
    end
    edge_();
    redirect_ack = 0; flush = 0; #1;
    check("release_redirect", redirect, 0);
    check("release_ready", issue_ready, 1);
    check("release_count", taken_count, exp_count);
  endtask

  function automatic logic rel_taken(input logic [2:0] c, input int a, input int b);
    case (c)
      3'd0: return a == b;
      3'd1: return a != b;
      3'd2: return a < b;
      3'd3: return a >= b;
      3'd4: return a > b;
      3'd5: return a <= b;
      3'd6: return 1'b1;
      default: return 1'b0;
    endcase
  endfunction

  initial begin
    Reset_n = 0; issue_valid = 0; flush = 0; redirect_ack = 0; cond = 0;
    pc = 0; offset = 0; lt_s = 0; eq_s = 0;
    s_rst_n = 0; s_issue = 0; s_ack = 0;

    // Vector table: first test-plan case, full cond sweep, illegal flag pair, wrap.
    add(3'd0, 0, 1, 16'h0010, 16'h0005, 1, 16'h0016);
    add(3'd0, 0, 0, 16'h0100, 16'h0020, 0, 16'h0121);
    add(3'd0, 1, 0, 16'h0100, 16'h0020, 0, 16'h0121);
    add(3'd0, 0, 1, 16'h0100, 16'h0020, 1, 16'h0121);
    add(3'd1, 0, 0, 16'h0100, 16'h0020, 1, 16'h0121);
    add(3'd1, 1, 0, 16'h0100, 16'h0020, 1, 16'h0121);
    add(3'd1, 0, 1, 16'h0100, 16'h0020, 0, 16'h0121);
    add(3'd2, 0, 0, 16'h0100, 16'h0020, 0, 16'h0121);
    add(3'd2, 1, 0, 16'h0100, 16'h0020, 1, 16'h0121);
    add(3'd2, 0, 1, 16'h0100, 16'h0020, 0, 16'h0121);
    add(3'd3, 0, 0, 16'h0100, 16'h0020, 1, 16'h0121);
    add(3'd3, 1, 0, 16'h0100, 16'h0020, 0, 16'h0121);
    add(3'd3, 0, 1, 16'h0100, 16'h0020, 1, 16'h0121);
    add(3'd4, 0, 0, 16'h0100, 16'h0020, 1, 16'h0121);
    add(3'd4, 1, 0, 16'h0100, 16'h0020, 0, 16'h0121);
    add(3'd4, 0, 1, 16'h0100, 16'h0020, 0, 16'h0121);
    add(3'd5, 0, 0, 16'h0100, 16'h0020, 0, 16'h0121);
    add(3'd5, 1, 0, 16'h0100, 16'h0020, 1, 16'h0121);
    add(3'd5, 0, 1, 16'h0100, 16'h0020, 1, 16'h0121);
    add(3'd6, 0, 0, 16'h0100, 16'h0020, 1, 16'h0121);
    add(3'd6, 1, 0, 16'h0100, 16'h0020, 1, 16'h0121);
    add(3'd6, 0, 1, 16'h0100, 16'h0020, 1, 16'h0121);
    add(3'd7, 0, 0, 16'h0100, 16'h0020, 0, 16'h0121);
    add(3'd7, 1, 0, 16'h0100, 16'h0020, 0, 16'h0121);
    add(3'd7, 0, 1, 16'h0100, 16'h0020, 0, 16'h0121);
    add(3'd0, 1, 1, 16'h0200, 16'h0001, 1, 16'h0202);
    add(3'd1, 1, 1, 16'h0200, 16'h0001, 0, 16'h0202);
    add(3'd3, 1, 1, 16'h0200, 16'h0001, 0, 16'h0202);
    add(3'd4, 1, 1, 16'h0200, 16'h0001, 0, 16'h0202);
    add(3'd5, 1, 1, 16'h0200, 16'h0001, 1, 16'h0202);
    add(3'd6, 0, 0, 16'hFFFE, 16'h0003, 1, 16'h0002);
    add(3'd6, 0, 0, 16'h0000, 16'hFFFF, 1, 16'h0000);

    #12;
    check("rst_ready", issue_ready, 1);
    check("rst_rv", resolve_valid, 0);
    check("rst_taken", taken, 0);
    check("rst_redirect", redirect, 0);
    check("rst_pc", redirect_pc, 0);
    check("rst_count", taken_count, 0);
    Reset_n = 1; s_rst_n = 1;
    edge_();

    foreach (vecs[i]) begin
      run_branch(vecs[i].c, vecs[i].l, vecs[i].e, vecs[i].p, vecs[i].o,
                 vecs[i].tk, vecs[i].tgt, i % 3, 0);
      if (i == 0) check("first_count", taken_count, 1);
    end

    // Long ack hold with ignored issue pulses.
    run_branch(3'd6, 0, 0, 16'h4000, 16'h0010, 1, 16'h4011, 5, 0);

    // Flush in EVAL, flush in REDIRECT.
    run_branch(3'd6, 0, 0, 16'h1000, 16'h0000, 1, 16'h1001, 0, 1);
    run_branch(3'd6, 0, 0, 16'h2000, 16'h0002, 1, 16'h2003, 2, 2);

    // Flush together with issue_valid in IDLE: nothing accepted.
    issue_valid = 1; flush = 1; cond = 3'd6;
    edge_();
    issue_valid = 0; flush = 0; #1;
    check("flush_idle_ready", issue_ready, 1);
    check("flush_idle_rv", resolve_valid, 0);
    edge_();
    check("flush_idle_redirect", redirect, 0);

    // Randomized branches against a relation-level model.
    for (int n = 0; n < 150; n++) begin
      int a, b, r;
      logic [2:0] c;
      logic [15:0] p, o, tgt;
      a = int'($urandom_range(0, 3)) - 1;
      b = int'($urandom_range(0, 3)) - 1;
      c = 3'($urandom);
      p = 16'($urandom);
      o = 16'($urandom);
      tgt = 16'((int'(p) + 1 + int'(o)) % 65536);
      r = int'($urandom_range(0, 7));
      run_branch(c, a < b, a == b, p, o, rel_taken(c, a, b), tgt,
                 int'($urandom_range(0, 3)), (r == 0) ? 1 : (r == 1) ? 2 : 0);
    end

    // Asynchronous reset in the middle of a redirect.
    issue_valid = 1; cond = 3'd6; pc = 16'h1234; offset = 16'h0000;
    edge_();
    issue_valid = 0;
    edge_();
    check("pre_reset_redirect", redirect, 1);
    #1 Reset_n = 0;
    #1;
    check("async_rst_redirect", redirect, 0);
    check("async_rst_count", taken_count, 0);
    check("async_rst_ready", issue_ready, 1);
    check("async_rst_pc", redirect_pc, 0);
    exp_count = 16'd0;
    #1 Reset_n = 1;
    edge_();
    run_branch(3'd6, 0, 0, 16'h0001, 16'h0001, 1, 16'h0003, 0, 0);

    // Saturation on the 4-bit instance: 17 taken branches, count holds at 0xF.
    for (int i = 0; i < 17; i++) begin
      s_issue = 1;
      edge_();
      s_issue = 0;
      edge_();
      s_ack = 1;
      edge_();
      s_ack = 0;
      check("sat_count", s_count, (i + 1 > 15) ? 15 : i + 1);
    end
    check("sat_ready", s_ready, 1);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
